wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of writeback queue entries; legal values are 2, 4 and 8.
REQ-002 Port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: reset is synchronous and active-low.
REQ-004 Port mem_valid, input, 1 bit: MEM stage presents a retiring instruction.
REQ-005 Port mem_ready, output, 1 bit: queue can accept this cycle.
REQ-006 Port mem_wreg, input, 1 bit: the instruction writes a register.
REQ-007 Port mem_wd, input, `RegAddrBus: destination register address.
REQ-008 Port mem_wdata, input, `RegBus: ALU result; ignored for loads.
REQ-009 Port mem_is_load, input, 1 bit: result arrives later on dmem_rdata.
REQ-010 Port dmem_rvalid, input, 1 bit: load data return strobe; loads return in issue order.
REQ-011 Port dmem_rdata, input, `RegBus: load data.
REQ-012 Ports wb_we (1 bit), wb_waddr (`RegAddrBus) and wb_wdata (`RegBus), outputs: registered write port driving regfile we/waddr/wdata.
REQ-013 Ports id_raddr1 and id_raddr2, inputs, `RegAddrBus: ID-stage read addresses used for the hazard check.
REQ-014 Ports pend_hit1 and pend_hit2, outputs, 1 bit: the matching read address has a queued, unwritten result.
REQ-015 Port stall_req, output, 1 bit: equals NOT mem_ready; routed to the pipeline controller.
REQ-016 Port rvalid_err, output, 1 bit: sticky flag for a dmem_rvalid received with no outstanding load.

Function
REQ-017 An entry holds {waddr, data, is_load, data_ok}; the queue is a circular FIFO with head and tail pointers and a count from 0 to DEPTH.
REQ-018 A transfer occurs when mem_valid and mem_ready are both 1.
REQ-019 mem_ready = (count < DEPTH); there is no full-bypass, so a full queue deasserts ready even when the head retires in the same cycle.
REQ-020 A transfer with mem_wreg=0, or with mem_wd=0, is accepted and discarded; it is not enqueued.
REQ-021 An enqueued non-load entry sets data=mem_wdata and data_ok=1.
REQ-022 An enqueued load entry sets data_ok=0.
REQ-023 Load fill: dmem_rvalid writes dmem_rdata into the oldest entry with is_load=1 and data_ok=0, then sets its data_ok; a second pointer tracks that entry.
REQ-024 dmem_rvalid with no unfilled load: the data is dropped, rvalid_err is set to 1 and stays 1 until reset.
REQ-025 Retire: when count>0 and head.data_ok=1, on the next edge wb_we=1, wb_waddr=head.waddr, wb_wdata=head.data, and head advances; otherwise wb_we=0.
REQ-026 At most one retire per cycle; retirement is strictly in order, and an unfilled load at head blocks all younger entries.
REQ-027 Latency: a non-load entry enqueued at edge N into an empty queue appears on wb_we at edge N+1.
REQ-028 Latency: a load filled at edge N while at head appears on wb_we at edge N+1.
REQ-029 Simultaneous enqueue, fill and retire in one cycle are all legal; count changes by (+1 enq) and (-1 retire).
REQ-030 A fill may target an entry being enqueued in the same cycle only if that entry becomes valid at that edge; it does not.
REQ-031 Pointers wrap modulo DEPTH.
REQ-032 pend_hit1 is combinational: 1 when id_raddr1 is not 0 and equals waddr of any valid queue entry; pend_hit2 is identical for id_raddr2.
REQ-033 The entry held in the wb_* output register is excluded from the pend_hit check, because the regfile forwards its own write port.
REQ-034 When the regfile receives a write whose waddr is x0, it ignores it.

Reset
REQ-035 With rst=0 at an edge: count, head, tail and the fill pointer are cleared to 0, all data_ok flags are cleared, wb_we=0, wb_waddr=0, wb_wdata=0 and rvalid_err=0.
REQ-036 Reset in mid-operation discards all queued entries and outstanding loads; a dmem_rvalid arriving after reset sets rvalid_err.
REQ-037 While rst=0, mem_ready=0 and pend_hit1=pend_hit2=0.

Verification
REQ-038 Empty queue; enqueue ALU op wd=5, wdata=0x1234 at edge N -> wb_we=1, wb_waddr=5, wb_wdata=0x1234 at edge N+1; pend_hit1 for raddr 5 is 0 after retire.
REQ-039 Enqueue a load wd=3 followed by ALU wd=4 data=0xAA; dmem_rvalid with 0xBEEF 3 cycles later -> r3=0xBEEF is written first, then r4=0xAA on the next edge; pend_hit for 4 stays 1 until then.
REQ-040 Issue DEPTH loads with no returns -> mem_ready=0 and stall_req=1; one return -> ready=1 one cycle after the head retires.
REQ-041 Enqueue with mem_wd=0 or mem_wreg=0 -> ready handshake completes, count unchanged, no wb_we pulse.
REQ-042 dmem_rvalid with an empty queue -> rvalid_err=1 and it holds; assert rst=0 for one edge -> rvalid_err=0 and the queue is empty.
REQ-043 Two loads outstanding, then rst=0 -> wb_we=0 and count=0 at the next edge; later returns only set rvalid_err.

Source files
------------

// File: rtl/wb_queue.sv
// Writeback queue between MEM and the regfile: in-order retirement of ALU results
// and load returns, with pending-write hazard lookup for the ID stage.
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegBus
`define RegBus 31:0
`endif

module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              mem_wreg,
    input  logic [`RegAddrBus] mem_wd,
    input  logic [`RegBus]    mem_wdata,
    input  logic              mem_is_load,
    input  logic              dmem_rvalid,
    input  logic [`RegBus]    dmem_rdata,
    output logic              wb_we,
    output logic [`RegAddrBus] wb_waddr,
    output logic [`RegBus]    wb_wdata,
    input  logic [`RegAddrBus] id_raddr1,
    input  logic [`RegAddrBus] id_raddr2,
    output logic              pend_hit1,
    output logic              pend_hit2,
    output logic              stall_req,
    output logic              rvalid_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

    logic [`RegAddrBus] q_waddr [DEPTH];
    logic [`RegBus]     q_data  [DEPTH];
    logic [DEPTH-1:0]   q_load;
    logic [DEPTH-1:0]   q_ok;

    logic [PW-1:0] head, tail, fill_ptr, nxt_fill, scan_idx;
    logic [PW:0]   count, load_cnt;
    logic [DEPTH-1:0] live;
    logic scan_found;
    logic enq, enq_load, fill, ret;

    // Handshake: a transfer happens on an edge where mem_valid && mem_ready; mem_valid
    // may be raised regardless of mem_ready, and mem_ready does not look at mem_valid.
    assign mem_ready = rst && (count < CNT_FULL);
    assign stall_req = !mem_ready;

    assign enq      = mem_valid && mem_ready && mem_wreg && (mem_wd != '0);
    assign enq_load = enq && mem_is_load;
    assign fill     = dmem_rvalid && (load_cnt != '0);
    assign ret      = (count != '0) && q_ok[head];

    always_comb begin
        live       = '0;
        pend_hit1  = 1'b0;
        pend_hit2  = 1'b0;
        nxt_fill   = fill_ptr;
        scan_idx   = '0;
        scan_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = {1'b0, PW'(PW'(i) - head)} < count;
            if (rst && live[i] && (id_raddr1 != '0) && (q_waddr[i] == id_raddr1))
                pend_hit1 = 1'b1;
            if (rst && live[i] && (id_raddr2 != '0) && (q_waddr[i] == id_raddr2))
                pend_hit2 = 1'b1;
        end
        // Loads fill in order, so the next target is the first load after fill_ptr.
        for (int k = 1; k < DEPTH; k++) begin
            scan_idx = PW'(fill_ptr + PW'(k));
            if (!scan_found && live[scan_idx] && q_load[scan_idx] && !q_ok[scan_idx]) begin
                nxt_fill   = scan_idx;
                scan_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count      <= '0;
            load_cnt   <= '0;
            head       <= '0;
            tail       <= '0;
            fill_ptr   <= '0;
            q_ok       <= '0;
            q_load     <= '0;
            wb_we      <= 1'b0;
            wb_waddr   <= '0;
            wb_wdata   <= '0;
            rvalid_err <= 1'b0;
        end else begin
            if (enq) begin
                q_waddr[tail] <= mem_wd;
                q_data[tail]  <= mem_wdata;
                q_load[tail]  <= mem_is_load;
                q_ok[tail]    <= !mem_is_load;
                tail          <= PW'(tail + PW'(1));
            end

            if (fill) begin
                q_data[fill_ptr] <= dmem_rdata;
                q_ok[fill_ptr]   <= 1'b1;
                if (load_cnt == CNT_ONE) begin
                    if (enq_load)
                        fill_ptr <= tail;
                end else begin
                    fill_ptr <= nxt_fill;
                end
            end else if ((load_cnt == '0) && enq_load) begin
                fill_ptr <= tail;
            end

            if (dmem_rvalid && (load_cnt == '0))
                rvalid_err <= 1'b1;

            wb_we <= ret;
            if (ret) begin
                wb_waddr <= q_waddr[head];
                wb_wdata <= q_data[head];
                head     <= PW'(head + PW'(1));
            end

            count    <= count + (PW+1)'(enq) - (PW+1)'(ret);
            load_cnt <= load_cnt + (PW+1)'(enq_load) - (PW+1)'(fill);
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios plus random traffic, checked every cycle
// against a queue-level model of pending writebacks.
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegBus
`define RegBus 31:0
`endif

module tb_wb_queue;
  localparam int DEPTH = 4;

  logic clk, rst;
  logic mem_valid, mem_ready, mem_wreg, mem_is_load;
  logic [`RegAddrBus] mem_wd, wb_waddr, id_raddr1, id_raddr2;
  logic [`RegBus] mem_wdata, dmem_rdata, wb_wdata;
  logic dmem_rvalid, wb_we, pend_hit1, pend_hit2, stall_req, rvalid_err;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wreg(mem_wreg),
    .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .stall_req(stall_req), .rvalid_err(rvalid_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected queue of pending writebacks, oldest first
  typedef struct packed {
    logic        ld;
    logic        ok;
    logic [4:0]  wa;
    logic [31:0] d;
  } ent_t;

  ent_t exp_q[$];
  logic exp_we = 1'b0;
  logic exp_err = 1'b0;
  logic [4:0] exp_wa = '0;
  logic [31:0] exp_wd = '0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_hit(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (exp_q[i]) if (exp_q[i].wa == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_unfilled();
    foreach (exp_q[i]) if (exp_q[i].ld && !exp_q[i].ok) return i;
    return -1;
  endfunction

  task automatic model_step();
    int fi;
    logic do_ret, do_enq;
    ent_t e;
    if (!rst) begin
      exp_q.delete();
      exp_we = 1'b0;
      exp_wa = '0;
      exp_wd = '0;
      exp_err = 1'b0;
    end else begin
      do_ret = (exp_q.size() > 0) && exp_q[0].ok;
      do_enq = mem_valid && (exp_q.size() < DEPTH) && mem_wreg && (mem_wd != 5'd0);
      if (dmem_rvalid) begin
        fi = m_unfilled();
        if (fi < 0) exp_err = 1'b1;
        else begin
          e = exp_q[fi];
          e.d = dmem_rdata;
          e.ok = 1'b1;
          exp_q[fi] = e;
        end
      end
      exp_we = do_ret;
      if (do_ret) begin
        e = exp_q.pop_front();
        exp_wa = e.wa;
        exp_wd = e.d;
      end
      if (do_enq) begin
        e.ld = mem_is_load;
        e.ok = !mem_is_load;
        e.wa = mem_wd;
        e.d = mem_is_load ? 32'h0 : mem_wdata;
        exp_q.push_back(e);
      end
    end
  endtask

  // one clock: check combinational outputs, take the edge, check registered outputs
  task automatic cyc();
    #1;
    check("mem_ready", 32'(mem_ready), 32'(rst && (exp_q.size() < DEPTH)));
    check("stall_req", 32'(stall_req), 32'(!(rst && (exp_q.size() < DEPTH))));
    check("pend_hit1", 32'(pend_hit1), 32'(rst && m_hit(id_raddr1)));
    check("pend_hit2", 32'(pend_hit2), 32'(rst && m_hit(id_raddr2)));
    @(posedge clk);
    model_step();
    #1;
    check("wb_we", 32'(wb_we), 32'(exp_we));
    check("wb_waddr", 32'(wb_waddr), 32'(exp_wa));
    check("wb_wdata", wb_wdata, exp_wd);
    check("rvalid_err", 32'(rvalid_err), 32'(exp_err));
    @(negedge clk);
  endtask

  // driver tasks
  task automatic idle_in();
    mem_valid = 1'b0;
    mem_wreg = 1'b0;
    mem_wd = '0;
    mem_wdata = '0;
    mem_is_load = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
  endtask

  task automatic push(input logic [4:0] wd, input logic [31:0] d, input logic ld, input logic wreg);
    mem_valid = 1'b1;
    mem_wreg = wreg;
    mem_wd = wd;
    mem_wdata = d;
    mem_is_load = ld;
    cyc();
    idle_in();
  endtask

  task automatic ret_load(input logic [31:0] d);
    dmem_rvalid = 1'b1;
    dmem_rdata = d;
    cyc();
    idle_in();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (m_unfilled() >= 0) ret_load($urandom);
      else if (exp_q.size() == 0) break;
      else cyc();
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    id_raddr1 = '0;
    id_raddr2 = '0;
    @(negedge clk);
    cyc();
    cyc();
    check("reset_wb_we", 32'(wb_we), 32'd0);
    check("reset_err", 32'(rvalid_err), 32'd0);
    rst = 1'b1;

    // ALU op retires one edge after enqueue
    push(5'd5, 32'h1234, 1'b0, 1'b1);
    id_raddr1 = 5'd5;
    cyc();
    check("alu_we", 32'(wb_we), 32'd1);
    check("alu_waddr", 32'(wb_waddr), 32'd5);
    check("alu_wdata", wb_wdata, 32'h1234);
    check("alu_hit_after", 32'(pend_hit1), 32'd0);

    // load blocks a younger ALU op until its data returns
    id_raddr1 = 5'd4;
    id_raddr2 = 5'd3;
    push(5'd3, 32'h0, 1'b1, 1'b1);
    push(5'd4, 32'hAA, 1'b0, 1'b1);
    check("blk_hit4", 32'(pend_hit1), 32'd1);
    cyc();
    cyc();
    ret_load(32'hBEEF);
    check("blk_hit4_fill", 32'(pend_hit1), 32'd1);
    cyc();
    check("blk_w3_addr", 32'(wb_waddr), 32'd3);
    check("blk_w3_data", wb_wdata, 32'hBEEF);
    check("blk_hit4_mid", 32'(pend_hit1), 32'd1);
    cyc();
    check("blk_w4_addr", 32'(wb_waddr), 32'd4);
    check("blk_w4_data", wb_wdata, 32'hAA);
    check("blk_hit4_done", 32'(pend_hit1), 32'd0);

    // full queue of loads: no bypass, ready returns after head retires
    for (int i = 0; i < DEPTH; i++) push(5'(i + 1), 32'h0, 1'b1, 1'b1);
    check("full_ready", 32'(mem_ready), 32'd0);
    check("full_stall", 32'(stall_req), 32'd1);
    ret_load(32'h77);
    check("full_ready_fill", 32'(mem_ready), 32'd0);
    cyc();
    check("full_ready_ret", 32'(mem_ready), 32'd1);
    drain();

    // discarded transfers
    push(5'd7, 32'h55, 1'b0, 1'b0);
    push(5'd0, 32'h66, 1'b0, 1'b1);
    cyc();
    check("discard_we", 32'(wb_we), 32'd0);
    check("discard_ready", 32'(mem_ready), 32'd1);

    // spurious load return is sticky until reset
    ret_load(32'h9);
    check("err_set", 32'(rvalid_err), 32'd1);
    cyc();
    check("err_hold", 32'(rvalid_err), 32'd1);
    do_reset();
    check("err_clear", 32'(rvalid_err), 32'd0);

    // reset with outstanding loads
    push(5'd3, 32'h0, 1'b1, 1'b1);
    push(5'd4, 32'h0, 1'b1, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_hit", 32'(pend_hit1), 32'd0);
    cyc();
    check("rst_we", 32'(wb_we), 32'd0);
    rst = 1'b1;
    ret_load(32'h1);
    check("rst_late_err", 32'(rvalid_err), 32'd1);
    do_reset();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      mem_valid = ($urandom_range(0, 1) == 1);
      mem_wreg = ($urandom_range(0, 7) != 0);
      mem_wd = 5'($urandom_range(0, 7));
      mem_wdata = $urandom;
      mem_is_load = ($urandom_range(0, 2) == 0);
      if (m_unfilled() >= 0) dmem_rvalid = ($urandom_range(0, 9) < 4);
      else dmem_rvalid = ($urandom_range(0, 49) == 0);
      dmem_rdata = $urandom;
      id_raddr1 = 5'($urandom_range(0, 7));
      id_raddr2 = 5'($urandom_range(0, 7));
      cyc();
    end
    rst = 1'b1;
    idle_in();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
